// File: rtl/exec_result_stage_pkg.sv
// Shared CPU constants: XNZVC flag bit positions and the 16 branch condition encodings.
// Imported by the result stage and by the condition evaluator.
package exec_result_stage_pkg;

    localparam int bitpos_X = 4;
    localparam int bitpos_N = 3;
    localparam int bitpos_Z = 2;
    localparam int bitpos_V = 1;
    localparam int bitpos_C = 0;

    typedef enum logic [3:0] {
        cc_T  = 4'd0,  cc_F  = 4'd1,  cc_HI = 4'd2,  cc_LS = 4'd3,
        cc_CC = 4'd4,  cc_CS = 4'd5,  cc_NE = 4'd6,  cc_EQ = 4'd7,
        cc_VC = 4'd8,  cc_VS = 4'd9,  cc_PL = 4'd10, cc_MI = 4'd11,
        cc_GE = 4'd12, cc_LT = 4'd13, cc_GT = 4'd14, cc_LE = 4'd15
    } cc_e;

    // New CCR after one accepted op; the sticky rule lets multi-word ops AND their Z results.
    function automatic logic [4:0] ccr_next(input logic [4:0] ccr, input logic [4:0] flags,
                                            input logic [4:0] mask, input logic zsticky);
        logic [4:0] r;
        r = (ccr & ~mask) | (flags & mask);
        if (zsticky && mask[bitpos_Z])
            r[bitpos_Z] = ccr[bitpos_Z] & flags[bitpos_Z];
        return r;
    endfunction

endpackage

// File: rtl/exec_result_stage_cond_eval.sv
// Combinational branch-condition evaluator over an XNZVC condition-code register.
// Shared with the branch unit.
module cond_eval
    import exec_result_stage_pkg::*;
(
    input  logic [4:0] ccr,
    input  logic [3:0] cond,
    output logic       cond_true
);

    logic n, z, v, c;

    always_comb begin
        n = ccr[bitpos_N];
        z = ccr[bitpos_Z];
        v = ccr[bitpos_V];
        c = ccr[bitpos_C];
        // NOTE: assigning a default before the case keeps this purely combinational (no latch).
        cond_true = 1'b0;
        case (cc_e'(cond))
            cc_T:  cond_true = 1'b1;
            cc_F:  cond_true = 1'b0;
            cc_HI: cond_true = !c && !z;
            cc_LS: cond_true = c || z;
            cc_CC: cond_true = !c;
            cc_CS: cond_true = c;
            cc_NE: cond_true = !z;
            cc_EQ: cond_true = z;
            cc_VC: cond_true = !v;
            cc_VS: cond_true = v;
            cc_PL: cond_true = !n;
            cc_MI: cond_true = n;
            cc_GE: cond_true = (n == v);
            cc_LT: cond_true = (n != v);
            cc_GT: cond_true = !z && (n == v);
            cc_LE: cond_true = z || (n != v);
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_result_stage.sv
// Registered ALU result stage: commits flags into the CCR on accept and forwards
// write-back results through a 2-entry (main + skid) FIFO with valid/ready handshake.
module exec_result_stage
    import exec_result_stage_pkg::*;
#(
    parameter int N    = 32,
    parameter int REGW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_RES,
    input  logic [4:0]      in_XNZVC,
    input  logic [4:0]      in_CCMASK,
    input  logic            in_ZSTICKY,
    input  logic            in_WEN,
    input  logic [REGW-1:0] in_DST,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_RES,
    output logic [REGW-1:0] out_DST,
    output logic [4:0]      out_CCR,
    output logic            out_X,
    input  logic [3:0]      in_COND,
    output logic            out_COND_TRUE
);

    logic [4:0]      ccr_q, ccr_d;
    logic            main_valid_q, main_valid_d;
    logic [N-1:0]    main_res_q, main_res_d;
    logic [REGW-1:0] main_dst_q, main_dst_d;
    logic            skid_valid_q, skid_valid_d;
    logic [N-1:0]    skid_res_q, skid_res_d;
    logic [REGW-1:0] skid_dst_q, skid_dst_d;
    logic            accept, enqueue, drain;

    assign in_ready  = ~skid_valid_q;
    assign accept    = in_valid & in_ready;
    assign enqueue   = accept & in_WEN;
    assign drain     = main_valid_q & out_ready;

    always_comb begin
        ccr_d        = ccr_q;
        main_valid_d = main_valid_q;
        main_res_d   = main_res_q;
        main_dst_d   = main_dst_q;
        skid_valid_d = skid_valid_q;
        skid_res_d   = skid_res_q;
        skid_dst_d   = skid_dst_q;

        if (accept)
            ccr_d = ccr_next(ccr_q, in_XNZVC, in_CCMASK, in_ZSTICKY);

        if (drain) begin
            if (skid_valid_q) begin
                main_res_d   = skid_res_q;
                main_dst_d   = skid_dst_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = 1'b0;
            end
        end

        // Enqueue never coincides with a full skid, since in_ready is low then.
        if (enqueue) begin
            if (!main_valid_q || drain) begin
                main_valid_d = 1'b1;
                main_res_d   = in_RES;
                main_dst_d   = in_DST;
            end else begin
                skid_valid_d = 1'b1;
                skid_res_d   = in_RES;
                skid_dst_d   = in_DST;
            end
        end
    end

    // NOTE: data registers are reset too so out_RES/out_DST read as zero after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ccr_q        <= '0;
            main_valid_q <= 1'b0;
            main_res_q   <= '0;
            main_dst_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_res_q   <= '0;
            skid_dst_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            ccr_q        <= ccr_d;
            main_valid_q <= main_valid_d;
            main_res_q   <= main_res_d;
            main_dst_q   <= main_dst_d;
            skid_valid_q <= skid_valid_d;
            skid_res_q   <= skid_res_d;
            skid_dst_q   <= skid_dst_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_RES   = main_res_q;
    assign out_DST   = main_dst_q;
    assign out_CCR   = ccr_q;
    assign out_X     = ccr_q[bitpos_X];

    cond_eval u_cond_eval (
        .ccr       (ccr_q),
        .cond      (in_COND),
        .cond_true (out_COND_TRUE)
    );

endmodule

// File: tb/tb_exec_result_stage.sv
// Self-checking bench for exec_result_stage: directed vector table, backpressure and
// reset sequences, then randomized traffic against a queue-based reference model.
module tb_exec_result_stage;

    localparam int N    = 32;
    localparam int REGW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_RES;
    logic [4:0]      in_XNZVC;
    logic [4:0]      in_CCMASK;
    logic            in_ZSTICKY;
    logic            in_WEN;
    logic [REGW-1:0] in_DST;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    out_RES;
    logic [REGW-1:0] out_DST;
    logic [4:0]      out_CCR;
    logic            out_X;
    logic [3:0]      in_COND;
    logic            out_COND_TRUE;

    exec_result_stage #(.N(N), .REGW(REGW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_RES        (in_RES),
        .in_XNZVC      (in_XNZVC),
        .in_CCMASK     (in_CCMASK),
        .in_ZSTICKY    (in_ZSTICKY),
        .in_WEN        (in_WEN),
        .in_DST        (in_DST),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_RES       (out_RES),
        .out_DST       (out_DST),
        .out_CCR       (out_CCR),
        .out_X         (out_X),
        .in_COND       (in_COND),
        .out_COND_TRUE (out_COND_TRUE)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a FIFO of pending write-backs and a CCR value.
    typedef struct {
        logic [N-1:0]    res;
        logic [REGW-1:0] dst;
    } entry_t;

    entry_t     mq[$];
    logic [4:0] m_ccr;

    // Flag order within XNZVC: X=4, N=3, Z=2, V=1, C=0.
    function automatic logic m_cond(input logic [4:0] ccr, input int cond);
        bit n, z, v, c;
        n = ccr[3]; z = ccr[2]; v = ccr[1]; c = ccr[0];
        case (cond)
            0:  return 1;
            1:  return 0;
            2:  return !c && !z;
            3:  return c || z;
            4:  return !c;
            5:  return c;
            6:  return !z;
            7:  return z;
            8:  return !v;
            9:  return v;
            10: return !n;
            11: return n;
            12: return n == v;
            13: return n != v;
            14: return !z && (n == v);
            default: return z || (n != v);
        endcase
    endfunction

    // Apply the current inputs to the model as if a rising edge occurred now.
    task automatic model_edge();
        bit acc, drn;
        entry_t e;
        acc = in_valid && (mq.size() < 2);
        drn = (mq.size() > 0) && out_ready;
        if (drn) void'(mq.pop_front());
        if (acc && in_WEN) begin
            e.res = in_RES;
            e.dst = in_DST;
            mq.push_back(e);
        end
        if (acc) begin
            for (int i = 0; i < 5; i++) begin
                if (in_CCMASK[i])
                    m_ccr[i] = (i == 2 && in_ZSTICKY) ? (m_ccr[i] & in_XNZVC[i]) : in_XNZVC[i];
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " out_valid"}, out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            check({tag, " out_RES"}, out_RES, mq[0].res);
            check({tag, " out_DST"}, out_DST, mq[0].dst);
        end
        check({tag, " in_ready"}, in_ready, mq.size() < 2);
        check({tag, " out_CCR"}, out_CCR, m_ccr);
        check({tag, " out_X"}, out_X, m_ccr[4]);
        check({tag, " cond_true"}, out_COND_TRUE, m_cond(m_ccr, int'(in_COND)));
    endtask

    task automatic drive(input logic v, input logic [N-1:0] res, input logic [4:0] f,
                         input logic [4:0] m, input logic zs, input logic w,
                         input logic [REGW-1:0] d, input logic ordy, input logic [3:0] cond);
        in_valid   = v;
        in_RES     = res;
        in_XNZVC   = f;
        in_CCMASK  = m;
        in_ZSTICKY = zs;
        in_WEN     = w;
        in_DST     = d;
        out_ready  = ordy;
        in_COND    = cond;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic            v;
        logic [N-1:0]    res;
        logic [4:0]      f, m;
        logic            zs, w;
        logic [REGW-1:0] d;
        logic            ordy;
        logic [3:0]      cond;
        logic            e_valid;
        logic [N-1:0]    e_res;
        logic [REGW-1:0] e_dst;
        logic [4:0]      e_ccr;
        logic            e_rdy;
        logic            e_ct;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic v, input logic [N-1:0] res, input logic [4:0] f,
                       input logic [4:0] m, input logic zs, input logic w,
                       input logic [REGW-1:0] d, input logic ordy, input logic [3:0] cond,
                       input logic ev, input logic [N-1:0] eres, input logic [REGW-1:0] edst,
                       input logic [4:0] eccr, input logic erdy, input logic ect);
        vec_t x;
        x.v = v; x.res = res; x.f = f; x.m = m; x.zs = zs; x.w = w; x.d = d;
        x.ordy = ordy; x.cond = cond; x.e_valid = ev; x.e_res = eres; x.e_dst = edst;
        x.e_ccr = eccr; x.e_rdy = erdy; x.e_ct = ect;
        vt.push_back(x);
    endtask

    logic [N-1:0] res_a, res_b, res_c;

    initial begin
        reset = 1'b1;
        drive(0, '0, '0, '0, 0, 0, '0, 0, 4'd0);
        m_ccr = '0;
        #12;
        check("reset out_valid", out_valid, 1'b0);
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_RES", out_RES, '0);
        check("reset out_DST", out_DST, '0);
        check("reset out_CCR", out_CCR, 5'b00000);
        check("reset out_X", out_X, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        //   v  res       f         m         zs w  d  ordy cond   ev eres      edst ccr       rdy ct
        add(1, 32'h8ff, 5'b10001, 5'b11111, 0, 1, 3, 1, 4'd7,  1, 32'h8ff, 3, 5'b10001, 1, 0);
        add(0, 32'h0,   5'b00000, 5'b00000, 0, 0, 0, 1, 4'd5,  0, 32'h0,   0, 5'b10001, 1, 1);
        add(1, 32'h0,   5'b01010, 5'b01110, 0, 0, 0, 1, 4'd9,  0, 32'h0,   0, 5'b11011, 1, 1);
        add(1, 32'h0,   5'b00100, 5'b00100, 1, 0, 0, 1, 4'd6,  0, 32'h0,   0, 5'b11011, 1, 1);
        add(1, 32'h0,   5'b00100, 5'b11111, 0, 0, 0, 1, 4'd7,  0, 32'h0,   0, 5'b00100, 1, 1);
        add(0, 32'h0,   5'b00000, 5'b00000, 0, 0, 0, 1, 4'd6,  0, 32'h0,   0, 5'b00100, 1, 0);
        add(0, 32'h0,   5'b00000, 5'b00000, 0, 0, 0, 1, 4'd14, 0, 32'h0,   0, 5'b00100, 1, 0);
        add(0, 32'h0,   5'b00000, 5'b00000, 0, 0, 0, 1, 4'd15, 0, 32'h0,   0, 5'b00100, 1, 1);
        add(0, 32'h0,   5'b00000, 5'b00000, 0, 0, 0, 1, 4'd12, 0, 32'h0,   0, 5'b00100, 1, 1);
        add(0, 32'h0,   5'b00000, 5'b00000, 0, 0, 0, 1, 4'd0,  0, 32'h0,   0, 5'b00100, 1, 1);
        add(0, 32'h0,   5'b00000, 5'b00000, 0, 0, 0, 1, 4'd1,  0, 32'h0,   0, 5'b00100, 1, 0);
        add(1, 32'h0,   5'b01000, 5'b11111, 0, 0, 0, 1, 4'd13, 0, 32'h0,   0, 5'b01000, 1, 1);
        add(0, 32'h0,   5'b00000, 5'b00000, 0, 0, 0, 1, 4'd11, 0, 32'h0,   0, 5'b01000, 1, 1);
        add(0, 32'h0,   5'b00000, 5'b00000, 0, 0, 0, 1, 4'd12, 0, 32'h0,   0, 5'b01000, 1, 0);
        add(1, 32'haa,  5'b00001, 5'b00001, 0, 1, 5, 0, 4'd5,  1, 32'haa,  5, 5'b01001, 1, 1);
        // Flags-only accept while the pending entry drains.
        add(1, 32'h0,   5'b00010, 5'b00010, 0, 0, 0, 1, 4'd9,  0, 32'h0,   0, 5'b01011, 1, 1);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].v, vt[i].res, vt[i].f, vt[i].m, vt[i].zs, vt[i].w, vt[i].d,
                  vt[i].ordy, vt[i].cond);
            tick();
            check($sformatf("vec%0d out_valid", i), out_valid, vt[i].e_valid);
            if (vt[i].e_valid) begin
                check($sformatf("vec%0d out_RES", i), out_RES, vt[i].e_res);
                check($sformatf("vec%0d out_DST", i), out_DST, vt[i].e_dst);
            end
            check($sformatf("vec%0d out_CCR", i), out_CCR, vt[i].e_ccr);
            check($sformatf("vec%0d out_X", i), out_X, vt[i].e_ccr[4]);
            check($sformatf("vec%0d in_ready", i), in_ready, vt[i].e_rdy);
            check($sformatf("vec%0d cond", i), out_COND_TRUE, vt[i].e_ct);
        end

        // Backpressure: A and B fill main and skid, C is refused until skid drains.
        res_a = 32'hA0A0_0001; res_b = 32'hB0B0_0002; res_c = 32'hC0C0_0003;
        drive(1, res_a, 5'b00000, 5'b00000, 0, 1, 1, 0, 4'd0);
        tick();
        check("bp A head", out_RES, res_a);
        check("bp A ready", in_ready, 1'b1);
        drive(1, res_b, 5'b00000, 5'b00000, 0, 1, 2, 0, 4'd0);
        tick();
        check("bp B head held", out_RES, res_a);
        check("bp skid full ready", in_ready, 1'b0);
        drive(1, res_c, 5'b11111, 5'b11111, 0, 1, 3, 0, 4'd0);
        #1;
        check("bp C presented ready", in_ready, 1'b0);
        tick();
        check("bp stall head", out_RES, res_a);
        check("bp stall dst", out_DST, 4'd1);
        check("bp C ignored ccr", out_CCR, 5'b01011);
        out_ready = 1'b1;
        tick();
        check("bp drain1 head", out_RES, res_b);
        check("bp drain1 dst", out_DST, 4'd2);
        check("bp drain1 ready", in_ready, 1'b1);
        check("bp drain1 ccr", out_CCR, 5'b01011);
        tick();
        check("bp drain2 head", out_RES, res_c);
        check("bp drain2 dst", out_DST, 4'd3);
        check("bp C accepted ccr", out_CCR, 5'b11111);
        in_valid = 1'b0;
        tick();
        check("bp empty", out_valid, 1'b0);

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive(($urandom_range(0, 9) < 7), $urandom, 5'($urandom), 5'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                  REGW'($urandom), ($urandom_range(0, 9) < 6), 4'($urandom));
            tick();
            check_model($sformatf("rnd%0d", cyc));
        end

        // Asynchronous reset with both entries occupied.
        drive(1, 32'h1111, 5'b11111, 5'b11111, 0, 1, 7, 0, 4'd0);
        tick();
        drive(1, 32'h2222, 5'b11011, 5'b11111, 0, 1, 8, 0, 4'd0);
        tick();
        check("pre-reset full", in_ready, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async reset out_valid", out_valid, 1'b0);
        check("async reset in_ready", in_ready, 1'b1);
        check("async reset out_CCR", out_CCR, 5'b00000);
        check("async reset out_X", out_X, 1'b0);
        check("async reset out_RES", out_RES, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
